if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013: instruction word presented while IF_ID_valid=0.
REQ-003 Reset is rst, synchronous, active-high; clock is clk.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 stall_i  in  1  hazard unit: hold IF/ID outputs and stop fetching.
REQ-007 redirect_i  in  1  EX stage: taken branch/jump, flush fetch.
REQ-008 redirect_pc  in  32  EX stage: new fetch address.
REQ-009 imem_req  out  1  fetch request valid.
REQ-010 imem_addr  out  32  fetch address; equals PC register.
REQ-011 imem_gnt  in  1  request accepted this cycle.
REQ-012 imem_rvalid  in  1  response valid; imem guarantees exactly 1 cycle after an accepted request.
REQ-013 imem_rdata  in  32  instruction word, qualified by imem_rvalid.
REQ-014 IF_ID_PC  out  32  PC of the instruction held in IF/ID.
REQ-015 IF_ID_instr  out  32  instruction held in IF/ID.
REQ-016 IF_ID_valid  out  1  IF/ID holds a real instruction.

Function
REQ-017 imem_req SHALL be 1 unless stall_i=1, redirect_i=1, rst=1, or skid buffer occupied.
REQ-018 Request accepted (imem_req & imem_gnt): PC <= PC+4, in-flight flag set, in-flight PC <= PC.
REQ-019 imem_req=1, imem_gnt=0: PC SHALL hold and the same address SHALL be re-requested next cycle.
REQ-020 Latency: request accepted at edge N -> IF_ID_valid=1 with that instruction after edge N+2, i.e. first visible in cycle N+2; back-to-back grants SHALL yield one instruction per cycle.
REQ-021 Not stalled, no redirect, imem_rvalid=1: IF_ID_instr <= imem_rdata, IF_ID_PC <= in-flight PC, IF_ID_valid <= 1.
REQ-022 Not stalled, no redirect, no response: IF_ID_valid <= 0, IF_ID_instr <= NOP_INSTR (bubble).
REQ-023 stall_i=1: IF_ID_PC, IF_ID_instr, IF_ID_valid SHALL hold their values.
REQ-024 redirect_i=1 SHALL take priority over stall_i: IF_ID_valid <= 0, IF_ID_instr <= NOP_INSTR, PC <= {redirect_pc[31:2],2'b00}, any response arriving that cycle discarded, skid buffer cleared, no request issued that cycle.
REQ-025 Next request after a redirect SHALL be issued the following cycle at the redirect address.
REQ-026 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.

Reset
REQ-027 On rst: PC=RESET_PC, in-flight flag=0, skid empty, IF_ID_PC=0, IF_ID_instr=NOP_INSTR, IF_ID_valid=0, imem_req=0.
REQ-028 rst asserted with a request in flight: the following response SHALL be discarded.
REQ-029 First request SHALL issue in the first cycle after rst deasserts.

Configuration
REQ-030 Macro IF_SKID_BUF_EN compiles in a one-entry skid buffer {pc, instr, valid}.
REQ-031 With IF_SKID_BUF_EN: a response arriving while stall_i=1 SHALL be stored in the skid buffer; in the first unstalled cycle IF/ID SHALL load from the skid, skid SHALL empty, and imem_req SHALL reassert the same cycle.
REQ-032 Without IF_SKID_BUF_EN: a response arriving while stall_i=1 SHALL be discarded and PC SHALL rewind to its in-flight PC so it is re-fetched after the stall.

Structure
REQ-033 Shared package SHALL hold NOP_INSTR, the RESET_PC default, and the width constant XLEN=32.
REQ-034 Skid buffer SHALL be sub-module if_skid_buf, instantiated only under IF_SKID_BUF_EN.

Verification
REQ-035 Reset, gnt=1 always, rdata=addr^32'hA5A5_0000 -> IF_ID_PC sequence 0,4,8 from cycle 2, one per cycle.
REQ-036 Stall 3 cycles with 32'h8 in flight -> IF/ID holds 32'h4; after release IF_ID_PC=32'h8 (next cycle with skid, two cycles later without), no skipped/duplicated PC.
REQ-037 redirect_i=1, redirect_pc=32'h0000_0102 while stalled -> IF_ID_valid=0 next cycle, imem_addr=32'h0000_0100 the cycle after, in-flight word dropped.
REQ-038 imem_gnt=0 for 2 cycles at addr 32'h10 -> imem_addr stays 32'h10, two bubbles with IF_ID_instr=32'h0000_0013.
REQ-039 RESET_PC=32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 rst asserted mid-stream with request in flight -> all outputs at reset values next cycle, stale response never reaches IF/ID.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants, skid entry type and PC alignment helper for the IF stage.
package if_fetch_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } skid_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction
endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_fetch_stage_skid_buf.sv
// One-entry skid buffer catching an imem response that lands during a stall.
module if_skid_buf
  import if_fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            store,
  input  logic            drain,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  output skid_entry_t     entry
);
  // store only happens while stalled, drain only while unstalled: never both
  always_ff @(posedge clk) begin
    if (rst || clear)  entry <= '0;
    else if (store)    entry <= '{pc: pc_in, instr: instr_in, valid: 1'b1};
    else if (drain)    entry.valid <= 1'b0;
  end
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, single outstanding imem request, IF/ID register.
// Define IF_SKID_BUF_EN to keep stall-time responses in a skid buffer instead of re-fetching.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [if_fetch_stage_pkg::XLEN-1:0] RESET_PC  = if_fetch_stage_pkg::RESET_PC_DEFAULT,
  parameter logic [if_fetch_stage_pkg::XLEN-1:0] NOP_INSTR = if_fetch_stage_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc,
  if_fetch_stage_if.master imem,
  output logic [XLEN-1:0] IF_ID_PC,
  output logic [XLEN-1:0] IF_ID_instr,
  output logic            IF_ID_valid
);
  logic [XLEN-1:0] pc, inflight_pc;
  logic            inflight, rsp, accept, rewind, skid_busy;
  skid_entry_t     skid;

  // responses are only trusted when we actually own a request in flight
  assign rsp            = inflight & imem.imem_rvalid;
  assign imem.imem_req  = ~(rst | stall_i | redirect_i | skid_busy);
  assign imem.imem_addr = pc;
  assign accept         = imem.imem_req & imem.imem_gnt;

`ifdef IF_SKID_BUF_EN
  if_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .clear    (redirect_i),
    .store    (rsp & stall_i),
    .drain    (~stall_i),
    .pc_in    (inflight_pc),
    .instr_in (imem.imem_rdata),
    .entry    (skid)
  );
  // the skid drains in the first unstalled cycle, so it only blocks while stalled
  assign skid_busy = skid.valid & stall_i;
  assign rewind    = 1'b0;
`else
  assign skid      = '0;
  assign skid_busy = 1'b0;
  assign rewind    = rsp & stall_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= accept;
      if (accept) inflight_pc <= pc;
      if (redirect_i)  pc <= align_pc(redirect_pc);
      else if (rewind) pc <= inflight_pc;
      else if (accept) pc <= pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      IF_ID_PC    <= '0;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_valid <= 1'b0;
    end else if (redirect_i) begin
      IF_ID_instr <= NOP_INSTR;
      IF_ID_valid <= 1'b0;
    end else if (!stall_i) begin
      if (skid.valid) begin
        IF_ID_PC    <= skid.pc;
        IF_ID_instr <= skid.instr;
        IF_ID_valid <= 1'b1;
      end else if (rsp) begin
        IF_ID_PC    <= inflight_pc;
        IF_ID_instr <= imem.imem_rdata;
        IF_ID_valid <= 1'b1;
      end else begin
        IF_ID_instr <= NOP_INSTR;
        IF_ID_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed table-driven bench for if_fetch_stage; second instance covers PC wrap.
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
`ifdef IF_SKID_BUF_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, stall, redir, gnt;
  logic [31:0] rpc;
  logic [31:0] pc_a, instr_a, pc_b, instr_b;
  logic        valid_a, valid_b;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  if_fetch_stage_if bus_a ();
  if_fetch_stage_if bus_b ();

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redir), .redirect_pc(rpc),
    .imem(bus_a), .IF_ID_PC(pc_a), .IF_ID_instr(instr_a), .IF_ID_valid(valid_a)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .stall_i(1'b0), .redirect_i(1'b0), .redirect_pc(32'h0),
    .imem(bus_b), .IF_ID_PC(pc_b), .IF_ID_instr(instr_b), .IF_ID_valid(valid_b)
  );

  // imem model: fixed one-cycle response, data = addr ^ KEY
  assign bus_a.imem_gnt = gnt;
  assign bus_b.imem_gnt = 1'b1;
  always @(posedge clk) begin
    bus_a.imem_rvalid <= bus_a.imem_req & bus_a.imem_gnt;
    bus_a.imem_rdata  <= bus_a.imem_addr ^ KEY;
    bus_b.imem_rvalid <= bus_b.imem_req & bus_b.imem_gnt;
    bus_b.imem_rdata  <= bus_b.imem_addr ^ KEY;
  end

  typedef struct {
    logic        stall, redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redir = 1'b0; rpc = '0; gnt = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_req",   32'(bus_a.imem_req), 32'h0);
    chk("rst_addr",  bus_a.imem_addr, 32'h0);
    chk("rst_pc",    pc_a, 32'h0);
    chk("rst_instr", instr_a, NOP);
    chk("rst_valid", 32'(valid_a), 32'h0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    //          stall redir rpc          gnt  req addr          v  pc            instr
    tbl[0]  = '{0, 0, 32'h0,        1,   1, 32'h0000_0000, 0, 32'h0,        NOP};
    tbl[1]  = '{0, 0, 32'h0,        1,   1, 32'h0000_0004, 0, 32'h0,        NOP};
    tbl[2]  = '{0, 0, 32'h0,        1,   1, 32'h0000_0008, 1, 32'h0,        32'hA5A5_0000};
    tbl[3]  = '{0, 0, 32'h0,        1,   1, 32'h0000_000C, 1, 32'h4,        32'hA5A5_0004};
    tbl[4]  = '{0, 0, 32'h0,        0,   1, 32'h0000_0010, 1, 32'h8,        32'hA5A5_0008};
    tbl[5]  = '{0, 0, 32'h0,        0,   1, 32'h0000_0010, 1, 32'hC,        32'hA5A5_000C};
    tbl[6]  = '{0, 0, 32'h0,        1,   1, 32'h0000_0010, 0, 32'h0,        NOP};
    tbl[7]  = '{0, 0, 32'h0,        1,   1, 32'h0000_0014, 0, 32'h0,        NOP};
    tbl[8]  = '{0, 0, 32'h0,        1,   1, 32'h0000_0018, 1, 32'h10,       32'hA5A5_0010};
    tbl[9]  = '{1, 1, 32'h0000_0102, 1,  0, 32'h0000_001C, 1, 32'h14,       32'hA5A5_0014};
    tbl[10] = '{0, 0, 32'h0,        1,   1, 32'h0000_0100, 0, 32'h0,        NOP};
    tbl[11] = '{0, 0, 32'h0,        1,   1, 32'h0000_0104, 0, 32'h0,        NOP};
    tbl[12] = '{0, 0, 32'h0,        1,   1, 32'h0000_0108, 1, 32'h100,      32'hA5A5_0100};
    tbl[13] = '{0, 0, 32'h0,        1,   1, 32'h0000_010C, 1, 32'h104,      32'hA5A5_0104};

    // streaming, grant stall, redirect while stalled
    do_reset();
    for (int i = 0; i < 14; i++) begin
      stall = tbl[i].stall; redir = tbl[i].redir; rpc = tbl[i].rpc; gnt = tbl[i].gnt;
      @(negedge clk);
      chk($sformatf("row%0d_req", i),   32'(bus_a.imem_req), 32'(tbl[i].req));
      chk($sformatf("row%0d_addr", i),  bus_a.imem_addr, tbl[i].addr);
      chk($sformatf("row%0d_valid", i), 32'(valid_a), 32'(tbl[i].valid));
      chk($sformatf("row%0d_instr", i), instr_a, tbl[i].instr);
      if (tbl[i].valid) chk($sformatf("row%0d_pc", i), pc_a, tbl[i].pc);
      tick();
    end

    // 3-cycle stall with 0x8 in flight, IF/ID showing 0x4
    do_reset();
    repeat (3) tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_pc", k),    pc_a, 32'h4);
      chk($sformatf("stall%0d_valid", k), 32'(valid_a), 32'h1);
      chk($sformatf("stall%0d_req", k),   32'(bus_a.imem_req), 32'h0);
      tick();
    end
    stall = 1'b0;
    @(negedge clk);
    chk("rel0_req",  32'(bus_a.imem_req), 32'h1);
    chk("rel0_addr", bus_a.imem_addr, SKID ? 32'hC : 32'h8);
    chk("rel0_pc",   pc_a, 32'h4);
    tick();
    @(negedge clk);
    chk("rel1_valid", 32'(valid_a), SKID ? 32'h1 : 32'h0);
    chk("rel1_instr", instr_a, SKID ? 32'hA5A5_0008 : NOP);
    tick();
    @(negedge clk);
    chk("rel2_pc",    pc_a, SKID ? 32'hC : 32'h8);
    chk("rel2_valid", 32'(valid_a), 32'h1);
    tick();
    @(negedge clk);
    chk("rel3_pc",    pc_a, SKID ? 32'h10 : 32'hC);
    tick();

    // reset asserted with 0x8 in flight
    do_reset();
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mrst0_req", 32'(bus_a.imem_req), 32'h0);
    tick();
    @(negedge clk);
    chk("mrst1_pc",    pc_a, 32'h0);
    chk("mrst1_instr", instr_a, NOP);
    chk("mrst1_valid", 32'(valid_a), 32'h0);
    chk("mrst1_addr",  bus_a.imem_addr, 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst2_req",   32'(bus_a.imem_req), 32'h1);
    chk("mrst2_addr",  bus_a.imem_addr, 32'h0);
    chk("mrst2_valid", 32'(valid_a), 32'h0);
    tick();
    @(negedge clk);
    chk("mrst3_valid", 32'(valid_a), 32'h0);
    chk("mrst3_instr", instr_a, NOP);
    tick();
    @(negedge clk);
    chk("mrst4_pc",    pc_a, 32'h0);
    chk("mrst4_instr", instr_a, 32'hA5A5_0000);
    tick();

    // PC wrap from RESET_PC = 0xFFFF_FFF8
    do_reset();
    begin
      logic [31:0] exp_addr [4];
      exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC;
      exp_addr[2] = 32'h0000_0000; exp_addr[3] = 32'h0000_0004;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk($sformatf("wrap%0d_addr", k), bus_b.imem_addr, exp_addr[k]);
        if (k >= 2) begin
          chk($sformatf("wrap%0d_pc", k),    pc_b, exp_addr[k-2]);
          chk($sformatf("wrap%0d_instr", k), instr_b, exp_addr[k-2] ^ KEY);
        end
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
